// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default sizing and frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_WIDTH   = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  // Clock cycles occupied by one frame on the line (start + data + stop bits).
  function automatic int uart_frame_len(input int data_width, input int clks_per_bit,
                                        input int stop_bits);
    return (1 + data_width + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick marks the last clk cycle of every serial bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running 0..CLKS_PER_BIT-1 counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || clear)   cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_sync.sv
// UART transmitter: valid/ready word in, LSB-first start/data/stop frame out.
module uart_tx_sync
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_sync: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_sync: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
    $error("uart_tx_sync: DATA_WIDTH must be 5..9");
  end

  // Bit counter covers data bits and stop bits; DATA_WIDTH >= 5 so it also fits STOP_BITS-1.
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e           state, state_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic                  tx_d;
  logic                  tick;
  logic                  accept;

  // tx_ready is high exactly in IDLE, so the handshake never looks at mid-frame inputs.
  assign accept = tx_valid && tx_ready;

  // Bit timer restarts while idle so the start bit gets a full period after accept.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state: every transition out of a bit happens on the period tick.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept)                         state_d = START;
      START: if (tick)                           state_d = DATA;
      DATA:  if (tick && bit_cnt == LAST_DATA)   state_d = STOP;
      STOP:  if (tick && bit_cnt == LAST_STOP)   state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  // Output/datapath next values, derived from the next state so outputs can be registered.
  always_comb begin
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    case (state)
      IDLE:    begin
                 bit_cnt_d = '0;
                 if (accept) shift_d = tx_data;
               end
      DATA:    if (tick) shift_d = shift >> 1;
      default: ;
    endcase
    if (tick && state != IDLE)
      bit_cnt_d = (state_d != state) ? '0 : bit_cnt + BW'(1);
    tx_d = (state_d == DATA) ? shift_d[0] : (state_d != START);
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift    <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      shift    <= shift_d;
      bit_cnt  <= bit_cnt_d;
      tx       <= tx_d;
      tx_ready <= (state_d == IDLE);
      busy     <= (state_d != IDLE);
    end
  end

endmodule
